// File: rtl/blowfish_pkg.sv
// Shared types and helpers for the iterative Blowfish engine: FSM states,
// key-table address map and the Feistel F function.
package blowfish_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    localparam int TBL_AW = 11;

    // P-array sits at the bottom of the table, S-boxes follow it.
    function automatic int p_base();
        return 0;
    endfunction

    function automatic int s_base(input int rounds);
        return rounds + 2;
    endfunction

    function automatic logic [TBL_AW-1:0] s_addr(input int sb, input int k, input logic [7:0] j);
        return TBL_AW'(sb + 256 * k + int'(j));
    endfunction

    function automatic logic [31:0] bf_f(input logic [31:0] s0, input logic [31:0] s1,
                                         input logic [31:0] s2, input logic [31:0] s3);
        return ((s0 + s1) ^ s2) + s3;
    endfunction

endpackage

// File: rtl/blowfish_round.sv
// One combinational Feistel round. l_mix is exported so the parent can
// address the S-boxes and feed the four words back in.
module blowfish_round
    import blowfish_pkg::*;
(
    input  logic [31:0] l_in,
    input  logic [31:0] r_in,
    input  logic [31:0] p_word,
    input  logic [31:0] s0_word,
    input  logic [31:0] s1_word,
    input  logic [31:0] s2_word,
    input  logic [31:0] s3_word,
    output logic [31:0] l_mix,
    output logic [31:0] l_out,
    output logic [31:0] r_out
);

    assign l_mix = l_in ^ p_word;
    // Swap is folded in: new L is R ^ F, new R is the mixed L.
    assign l_out = r_in ^ bf_f(s0_word, s1_word, s2_word, s3_word);
    assign r_out = l_mix;

endmodule

// File: rtl/blowfish_cbc_engine.sv
// Iterative Blowfish core with ECB/CBC chaining, RPC rounds per clock and a
// firmware-loaded key table. One block in flight at a time.
module blowfish_cbc_engine
    import blowfish_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int RPC    = 1,
    parameter int CBC_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tbl_we,
    input  logic [10:0] tbl_addr,
    input  logic [31:0] tbl_wdata,
    output logic        tbl_ready,
    input  logic        iv_load,
    input  logic [63:0] iv,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        enc,
    input  logic        cbc,
    input  logic [63:0] din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] dout,
    output logic        out_enc
);

    localparam int NCYC      = ROUNDS / RPC;
    localparam int CW        = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int TBL_WORDS = ROUNDS + 1026;
    localparam int SB        = s_base(ROUNDS);
    localparam int PB        = p_base();
    localparam bit USE_CBC   = (CBC_EN != 0);

    logic [31:0]   tbl_mem [0:TBL_WORDS-1];
    state_e        state_reg;
    logic [31:0]   l_reg, r_reg;
    logic          enc_reg, cbc_reg, out_enc_reg;
    logic [63:0]   chain_reg, next_chain_reg, dout_reg;
    logic [CW-1:0] cnt_reg;

    logic          idle, cbc_eff;
    logic [31:0]   l_last, r_last, p_fin_l, p_fin_r;
    logic [63:0]   blk_in, blk_fin, dout_fin;

    assign idle      = (state_reg == ST_IDLE);
    assign tbl_ready = idle;
    assign in_ready  = idle;
    assign out_valid = (state_reg == ST_OUT);
    assign dout      = dout_reg;
    assign out_enc   = out_enc_reg;

    // Key table is deliberately not reset; firmware reloads it when needed.
    always_ff @(posedge clk) begin
        if (tbl_we && idle && (tbl_addr < TBL_AW'(TBL_WORDS)))
            tbl_mem[tbl_addr] <= tbl_wdata;
    end

    genvar gi;
    generate
        for (gi = 0; gi < RPC; gi++) begin : g_rnd
            logic [TBL_AW-1:0] ridx, p_addr;
            logic [31:0]       l_src, r_src, l_mix, l_nxt, r_nxt;

            if (gi == 0) begin : g_src
                assign l_src = l_reg;
                assign r_src = r_reg;
            end else begin : g_src
                assign l_src = g_rnd[gi-1].l_nxt;
                assign r_src = g_rnd[gi-1].r_nxt;
            end

            assign ridx   = TBL_AW'(cnt_reg) * TBL_AW'(RPC) + TBL_AW'(gi);
            assign p_addr = enc_reg ? (TBL_AW'(PB) + ridx) : (TBL_AW'(PB + ROUNDS + 1) - ridx);

            blowfish_round u_round (
                .l_in    (l_src),
                .r_in    (r_src),
                .p_word  (tbl_mem[p_addr]),
                .s0_word (tbl_mem[s_addr(SB, 0, l_mix[31:24])]),
                .s1_word (tbl_mem[s_addr(SB, 1, l_mix[23:16])]),
                .s2_word (tbl_mem[s_addr(SB, 2, l_mix[15:8])]),
                .s3_word (tbl_mem[s_addr(SB, 3, l_mix[7:0])]),
                .l_mix   (l_mix),
                .l_out   (l_nxt),
                .r_out   (r_nxt)
            );
        end
    endgenerate

    assign l_last = g_rnd[RPC-1].l_nxt;
    assign r_last = g_rnd[RPC-1].r_nxt;

    // Output whitening, with the final swap undone by the operand order.
    assign p_fin_l  = tbl_mem[enc_reg ? TBL_AW'(PB + ROUNDS + 1) : TBL_AW'(PB)];
    assign p_fin_r  = tbl_mem[enc_reg ? TBL_AW'(PB + ROUNDS) : TBL_AW'(PB + 1)];
    assign blk_fin  = {r_last ^ p_fin_l, l_last ^ p_fin_r};
    assign dout_fin = (!enc_reg && cbc_reg) ? (blk_fin ^ chain_reg) : blk_fin;

    assign cbc_eff = cbc & USE_CBC;
    assign blk_in  = (enc && cbc_eff) ? (din ^ chain_reg) : din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            l_reg          <= '0;
            r_reg          <= '0;
            enc_reg        <= 1'b0;
            cbc_reg        <= 1'b0;
            out_enc_reg    <= 1'b0;
            chain_reg      <= '0;
            next_chain_reg <= '0;
            dout_reg       <= '0;
            cnt_reg        <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (iv_load) begin
                        if (USE_CBC)
                            chain_reg <= iv;
                    end else if (in_valid) begin
                        enc_reg          <= enc;
                        cbc_reg          <= cbc_eff;
                        {l_reg, r_reg}   <= blk_in;
                        if (!enc && cbc_eff)
                            next_chain_reg <= din;
                        cnt_reg          <= '0;
                        state_reg        <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    l_reg <= l_last;
                    r_reg <= r_last;
                    if (cnt_reg == CW'(NCYC - 1)) begin
                        cnt_reg     <= '0;
                        state_reg   <= ST_OUT;
                        dout_reg    <= dout_fin;
                        out_enc_reg <= enc_reg;
                        if (cbc_reg)
                            chain_reg <= enc_reg ? blk_fin : next_chain_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blowfish_cbc_engine.sv
// Directed bench for blowfish_cbc_engine: pi digits are generated with a
// Machin-formula bignum, key tables are expanded in software and loaded.
module tb_blowfish_cbc_engine;

    localparam int ROUNDS = 16;
    localparam int TB_RPC = 1;
    localparam int LAT    = ROUNDS / TB_RPC;
    localparam int NW     = ROUNDS + 1026;
    localparam int BN     = NW + 4;
    localparam int SBB    = ROUNDS + 2;
    localparam logic [63:0] CT1 = 64'h4EF997456198DD78;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tbl_we = 1'b0;
    logic [10:0] tbl_addr = '0;
    logic [31:0] tbl_wdata = '0;
    logic        tbl_ready;
    logic        iv_load = 1'b0;
    logic [63:0] iv = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        enc = 1'b0;
    logic        cbc = 1'b0;
    logic [63:0] din = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] dout;
    logic        out_enc;

    always #5 clk = ~clk;

    blowfish_cbc_engine #(.ROUNDS(ROUNDS), .RPC(TB_RPC), .CBC_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .tbl_ready (tbl_ready),
        .iv_load   (iv_load),
        .iv        (iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enc       (enc),
        .cbc       (cbc),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_enc   (out_enc)
    );

    int checks = 0;
    int failures = 0;

    bit [31:0] pi_w    [0:NW-1];
    bit [31:0] ks_tab  [0:NW-1];
    bit [31:0] bn_sum  [0:BN-1];
    bit [31:0] bn_pow  [0:BN-1];
    bit [31:0] bn_term [0:BN-1];
    int        lead;

    typedef struct {
        string     name;
        bit [31:0] key_w;
        bit        do_iv;
        bit        e;
        bit        c;
        bit [63:0] d;
        bit [63:0] x;
    } vec_t;
    vec_t vecs [0:7];

    // ---------------- bignum pi (word 0 = integer part) ----------------
    task automatic div_pow(input longint unsigned dv);
        longint unsigned cur, rem;
        rem = 0;
        for (int i = lead; i < BN; i++) begin
            cur       = (rem << 32) | {32'b0, bn_pow[i]};
            bn_pow[i] = 32'(cur / dv);
            rem       = cur % dv;
        end
        while (lead < BN && bn_pow[lead] == 32'd0) lead++;
    endtask

    task automatic make_term(input longint unsigned dv);
        longint unsigned cur, rem;
        rem = 0;
        for (int i = lead; i < BN; i++) begin
            cur        = (rem << 32) | {32'b0, bn_pow[i]};
            bn_term[i] = 32'(cur / dv);
            rem        = cur % dv;
        end
    endtask

    task automatic acc_term(input bit sub);
        longint unsigned s, t, c;
        c = 0;
        for (int i = BN - 1; i >= 0; i--) begin
            if (i < lead && c == 0) break;
            t = (i >= lead) ? {32'b0, bn_term[i]} : 64'd0;
            if (sub) s = {32'b0, bn_sum[i]} - t - c;
            else     s = {32'b0, bn_sum[i]} + t + c;
            bn_sum[i] = s[31:0];
            c = sub ? {63'b0, s[63]} : (s >> 32);
        end
    endtask

    task automatic atan_series(input int unsigned x, input int unsigned mult, input bit neg0);
        int unsigned k;
        bit          neg;
        for (int i = 0; i < BN; i++) bn_pow[i] = 32'd0;
        bn_pow[0] = mult;
        lead = 0;
        div_pow(x);
        k   = 0;
        neg = neg0;
        while (lead < BN) begin
            make_term(2 * k + 1);
            acc_term(neg);
            div_pow(x * x);
            k++;
            neg = ~neg;
        end
    endtask

    task automatic compute_pi();
        for (int i = 0; i < BN; i++) bn_sum[i] = 32'd0;
        atan_series(5, 16, 1'b0);
        atan_series(239, 4, 1'b1);
        for (int i = 0; i < NW; i++) pi_w[i] = bn_sum[i + 1];
    endtask

    // ---------------- software Blowfish for key expansion ----------------
    function automatic bit [31:0] m_f(input bit [31:0] x);
        return ((ks_tab[SBB + x[31:24]] + ks_tab[SBB + 256 + x[23:16]]) ^
                ks_tab[SBB + 512 + x[15:8]]) + ks_tab[SBB + 768 + x[7:0]];
    endfunction

    function automatic bit [63:0] m_crypt(input bit [63:0] blk, input bit e);
        bit [31:0] l, r, t;
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < ROUNDS; i++) begin
            l = l ^ ks_tab[e ? i : ROUNDS + 1 - i];
            r = r ^ m_f(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        if (e) begin r = r ^ ks_tab[ROUNDS]; l = l ^ ks_tab[ROUNDS + 1]; end
        else   begin r = r ^ ks_tab[1];      l = l ^ ks_tab[0];          end
        return {l, r};
    endfunction

    // The key is 8 bytes of one repeated 32-bit word, so every P word sees kw.
    task automatic build_key(input bit [31:0] kw);
        bit [63:0] blk;
        for (int i = 0; i < NW; i++) ks_tab[i] = pi_w[i];
        for (int i = 0; i < ROUNDS + 2; i++) ks_tab[i] = ks_tab[i] ^ kw;
        blk = 64'd0;
        for (int i = 0; i < NW; i += 2) begin
            blk           = m_crypt(blk, 1'b1);
            ks_tab[i]     = blk[63:32];
            ks_tab[i + 1] = blk[31:0];
        end
    endtask

    // ---------------- DUT helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < NW; i++) begin
            tbl_we    = 1'b1;
            tbl_addr  = 11'(i);
            tbl_wdata = ks_tab[i];
            tick();
        end
        tbl_we = 1'b0;
    endtask

    task automatic start_block(input bit e, input bit c, input bit [63:0] d);
        in_valid = 1'b1;
        enc      = e;
        cbc      = c;
        din      = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int cyc0, output int cyc);
        cyc = cyc0;
        while (!out_valid && cyc < 4 * LAT + 10) begin
            tick();
            cyc++;
        end
    endtask

    task automatic end_block(input string nm, input bit e, input bit [63:0] x, input int cyc0);
        int cyc;
        wait_out(cyc0, cyc);
        $display("txn %s enc=%0d din=%h dout=%h out_enc=%0d lat=%0d", nm, e, din, dout, out_enc, cyc);
        chk({nm, "_lat"}, cyc, LAT);
        chk({nm, "_dout"}, dout, x);
        chk({nm, "_enc"}, out_enc, e);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_block(input string nm, input bit e, input bit c, input bit [63:0] d,
                             input bit [63:0] x);
        start_block(e, c, d);
        end_block(nm, e, x, 0);
    endtask

    task automatic set_vec(input int i, input string n, input bit [31:0] k, input bit v,
                           input bit e, input bit c, input bit [63:0] d, input bit [63:0] x);
        vecs[i].name  = n;
        vecs[i].key_w = k;
        vecs[i].do_iv = v;
        vecs[i].e     = e;
        vecs[i].c     = c;
        vecs[i].d     = d;
        vecs[i].x     = x;
    endtask

    initial begin
        bit [63:0] ct2, exp_mod;
        bit [31:0] loaded_key, saved;
        bit        have_key;
        int        cyc;
        bit        seen;

        compute_pi();
        build_key(32'h0);
        ct2 = m_crypt(CT1, 1'b1);

        set_vec(0, "t1_enc",  32'h0,        0, 1, 0, 64'h0,                CT1);
        set_vec(1, "t1_dec",  32'h0,        0, 0, 0, CT1,                  64'h0);
        set_vec(2, "t2_enc",  32'hFFFFFFFF, 0, 1, 0, 64'hFFFFFFFFFFFFFFFF, 64'h51866FD5B85ECB8A);
        set_vec(3, "t2_dec",  32'hFFFFFFFF, 0, 0, 0, 64'h51866FD5B85ECB8A, 64'hFFFFFFFFFFFFFFFF);
        set_vec(4, "t3_cbc_e1", 32'h0,      1, 1, 1, 64'h0,                CT1);
        set_vec(5, "t3_cbc_e2", 32'h0,      0, 1, 1, 64'h0,                ct2);
        set_vec(6, "t3_cbc_d1", 32'h0,      1, 0, 1, CT1,                  64'h0);
        set_vec(7, "t3_cbc_d2", 32'h0,      0, 0, 1, ct2,                  64'h0);

        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_tbl_ready", tbl_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 64'h0);
        chk("rst_out_enc", out_enc, 0);

        have_key   = 1'b0;
        loaded_key = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (!have_key || vecs[i].key_w != loaded_key) begin
                build_key(vecs[i].key_w);
                load_table();
                loaded_key = vecs[i].key_w;
                have_key   = 1'b1;
            end
            if (vecs[i].do_iv) begin
                iv      = 64'h0;
                iv_load = 1'b1;
                tick();
                iv_load = 1'b0;
            end
            run_block(vecs[i].name, vecs[i].e, vecs[i].c, vecs[i].d, vecs[i].x);
        end

        // iv_load and in_valid together: iv wins, block taken next cycle
        iv       = CT1;
        iv_load  = 1'b1;
        in_valid = 1'b1;
        enc      = 1'b1;
        cbc      = 1'b1;
        din      = 64'h0;
        tick();
        iv_load = 1'b0;
        chk("ivc_not_accepted", in_ready, 1);
        run_block("ivc_blk", 1, 1, 64'h0, ct2);

        // table write and accept in the same cycle; dropped writes while busy
        saved     = ks_tab[0];
        ks_tab[0] = saved ^ 32'h1;
        exp_mod   = m_crypt(64'h0, 1'b1);
        ks_tab[0] = saved;
        tbl_we    = 1'b1;
        tbl_addr  = 11'd0;
        tbl_wdata = saved ^ 32'h1;
        start_block(1, 0, 64'h0);
        tbl_addr  = 11'd5;
        tbl_wdata = 32'hDEADBEEF;
        iv_load   = 1'b1;
        iv        = 64'h0123456789ABCDEF;
        tick();
        tbl_we  = 1'b0;
        iv_load = 1'b0;
        end_block("tbl_collide", 1, exp_mod, 1);
        tbl_we    = 1'b1;
        tbl_addr  = 11'd0;
        tbl_wdata = saved;
        tick();
        tbl_we = 1'b0;
        run_block("drop_chk", 1, 1, ct2, CT1);

        // backpressure with a waiting block
        in_valid = 1'b1;
        enc      = 1'b1;
        cbc      = 1'b0;
        din      = 64'h0;
        tick();
        wait_out(0, cyc);
        chk("bp_lat", cyc, LAT);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_dout", dout, CT1);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        $display("txn bp_first dout=%h held 10 cycles", dout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_accept", in_ready, 0);
        end_block("bp_second", 1, CT1, 0);

        // reset mid-flight
        start_block(1, 0, 64'h0);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_tbl_ready", tbl_ready, 1);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_dout", dout, 64'h0);
        chk("mrst_out_enc", out_enc, 0);
        repeat (2) tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mrst_no_out", seen, 0);
        run_block("rst_chain", 1, 1, 64'h0, CT1);
        run_block("rst_t1", 1, 0, 64'h0, CT1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
